// File: rtl/alu_pkg.sv
// Shared definitions for the parameterised ALU.
// Holds the one-hot opcode constants and the control FSM state encoding
// used by param_alu.
package alu_pkg;

  localparam int unsigned OpW = 6;

  // One-hot opcodes carried on the operator port
  localparam logic [OpW-1:0] OpAdd = 6'b000001;
  localparam logic [OpW-1:0] OpSub = 6'b000010;
  localparam logic [OpW-1:0] OpMul = 6'b000100;
  localparam logic [OpW-1:0] OpPop = 6'b001000;  // One_Bits_Number
  localparam logic [OpW-1:0] OpXor = 6'b010000;
  localparam logic [OpW-1:0] OpMax = 6'b100000;  // Bigger_number

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDone = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add unsigned multiplier.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   start_i       : load operands (a_i, b_i) and begin a multiply
//   a_i, b_i      : Width-bit unsigned operands
//   done_o        : product is complete (held until the next edge)
//   prod_o        : 2*Width-bit product, valid while done_o is high
// The start edge already folds in multiplier bit 0, so done_o is high in the
// Width-th cycle after start and the caller can capture prod_o on that edge.
module alu_shift_add_mul #(
  parameter int unsigned Width = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [Width-1:0]     a_i,
  input  logic [Width-1:0]     b_i,
  output logic                 done_o,
  output logic [2*Width-1:0]   prod_o
);

  localparam int unsigned PW   = 2 * Width;
  localparam int unsigned CntW = $clog2(Width + 1);

  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [Width-1:0] mplier_q, mplier_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      acc_d    = b_i[0] ? PW'(a_i) : '0;
      mcand_d  = PW'(a_i) << 1;
      mplier_d = b_i >> 1;
      cnt_d    = CntW'(1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == CntW'(Width)) begin
        busy_d = 1'b0;
      end else begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign done_o = busy_q && (cnt_q == CntW'(Width));
  assign prod_o = acc_q;

endmodule

// File: rtl/param_alu.sv
// Parameterised handshaked ALU with a one-hot opcode.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : request handshake (ready only in IDLE)
//   num1, num2          : WIDTH-bit unsigned operands
//   operator            : one-hot opcode (Add, Sub, Mul, popcount, XOR, max)
//   out / out_valid     : OUT_W-bit result, held until out_ready
//   out_ready           : consumer accepts the result
//   odd_balance         : XOR-reduction of out
//   equality            : num1 == num2 for the accepted request
//   illegal_op          : opcode was not exactly one-hot
// Single-cycle ops go IDLE -> DONE; Mul spends WIDTH cycles in MUL.
module param_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [OpW-1:0]   operator,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             odd_balance,
  output logic             equality,
  output logic             illegal_op
);

  if (OUT_W < 2 * WIDTH) begin : g_bad_out_w
    $error("param_alu: OUT_W must be at least 2*WIDTH");
  end
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("param_alu: WIDTH must be in 2..16");
  end

  alu_state_e       state_q, state_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             odd_q, odd_d;
  logic             eq_q, eq_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic             op_legal;
  logic             mul_start;
  logic             mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [OUT_W-1:0] alu_res;

  assign in_ready  = (state_q == StIdle);
  assign accept    = in_valid && in_ready;
  assign op_legal  = $onehot(operator);
  assign mul_start = accept && (operator == OpMul);

  alu_shift_add_mul #(
    .Width (WIDTH)
  ) u_mul (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (mul_start),
    .a_i     (num1),
    .b_i     (num2),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  // Single-cycle result; anything not one-hot (and Mul) falls to zero here.
  always_comb begin
    alu_res = '0;
    case (operator)
      OpAdd: alu_res = OUT_W'(num1) + OUT_W'(num2);
      OpSub: alu_res = OUT_W'(num1) - OUT_W'(num2);
      OpPop: begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          alu_res = alu_res + OUT_W'(num1[i]) + OUT_W'(num2[i]);
        end
      end
      OpXor: alu_res = OUT_W'(num1 ^ num2);
      OpMax: alu_res = OUT_W'((num1 > num2) ? num1 : num2);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    odd_d       = odd_q;
    eq_d        = eq_q;
    illegal_d   = illegal_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          eq_d      = (num1 == num2);
          illegal_d = !op_legal;
          if (mul_start) begin
            state_d = StMul;
          end else begin
            state_d     = StDone;
            out_d       = alu_res;
            odd_d       = ^alu_res;
            out_valid_d = 1'b1;
          end
        end
      end
      StMul: begin
        if (mul_done) begin
          state_d     = StDone;
          out_d       = OUT_W'(mul_prod);
          odd_d       = ^mul_prod;
          out_valid_d = 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      odd_q       <= 1'b0;
      eq_q        <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      odd_q       <= odd_d;
      eq_q        <= eq_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign odd_balance = odd_q;
  assign equality    = eq_q;
  assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_param_alu.sv
// Self-checking bench for param_alu (WIDTH=5, OUT_W=32): a transaction-level
// model checked every cycle, plus directed vectors with literal expectations.
module tb_param_alu;

  localparam int unsigned WIDTH = 5;
  localparam int unsigned OUT_W = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic [5:0]       operator;
  logic [OUT_W-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             odd_balance;
  logic             equality;
  logic             illegal_op;

  param_alu #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .num1        (num1),
    .num2        (num2),
    .operator    (operator),
    .out         (out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .odd_balance (odd_balance),
    .equality    (equality),
    .illegal_op  (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Result from the arithmetic definitions of each operation
  function automatic logic [31:0] model_result(input logic [5:0] op, input int a, input int b);
    case (op)
      6'b000001: return 32'(a + b);
      6'b000010: return 32'(a - b);
      6'b000100: return 32'(a * b);
      6'b001000: return 32'($countones(a) + $countones(b));
      6'b010000: return 32'(a ^ b);
      6'b100000: return 32'((a > b) ? a : b);
      default:   return 32'd0;
    endcase
  endfunction

  // Transaction-level model: busy from accept until the result is taken
  bit          m_live  = 0;
  bit          m_busy  = 0;
  bit          m_valid = 0;
  bit          m_clean = 0;
  int          m_wait  = 0;
  logic [31:0] m_out;
  logic        m_odd, m_eq, m_ill;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_live = 1; m_busy = 0; m_valid = 0; m_clean = 1; m_wait = 0;
      m_out = 0; m_odd = 0; m_eq = 0; m_ill = 0;
    end else if (m_live) begin
      if (!m_busy) begin
        if (in_valid) begin
          m_clean = 0;
          m_busy  = 1;
          m_ill   = ($countones(operator) != 1);
          m_out   = model_result(operator, int'(num1), int'(num2));
          m_odd   = ^m_out;
          m_eq    = (num1 == num2);
          m_wait  = (operator == 6'b000100) ? WIDTH : 0;
          m_valid = (m_wait == 0);
        end
      end else if (!m_valid) begin
        m_wait--;
        if (m_wait == 0) m_valid = 1;
      end else if (out_ready) begin
        m_busy  = 0;
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("in_ready", 32'(in_ready), 32'(!m_busy));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid || m_clean) begin
        check("out", out, m_out);
        check("odd_balance", 32'(odd_balance), 32'(m_odd));
        check("equality", 32'(equality), 32'(m_eq));
        check("illegal_op", 32'(illegal_op), 32'(m_ill));
      end
    end
  end

  task automatic issue(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b);
    @(posedge clk);
    #1;
    operator = op; num1 = a; num2 = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    num1 = 5'($urandom);
    num2 = 5'($urandom);
    operator = 6'($urandom);
  endtask

  // Cycles from the accept cycle until out_valid is seen (1 = next cycle)
  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid === 1'b1) break;
    end
    if (lat >= 20) begin
      errors++;
      $display("FAIL %s_timeout: out_valid not seen within 20 cycles", name);
    end
  endtask

  task automatic run(input string name, input logic [5:0] op, input logic [4:0] a,
                     input logic [4:0] b, input int exp_lat, input logic [31:0] exp_out,
                     input logic exp_odd, input logic exp_eq, input logic exp_ill);
    int lat;
    issue(op, a, b);
    wait_valid(name, lat);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_out"}, out, exp_out);
    check({name, "_odd"}, 32'(odd_balance), 32'(exp_odd));
    check({name, "_eq"}, 32'(equality), 32'(exp_eq));
    check({name, "_ill"}, 32'(illegal_op), 32'(exp_ill));
  endtask

  initial begin
    int lat;
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    num1 = '0; num2 = '0; operator = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out", out, 32'd0);

    run("add", 6'b000001, 5'd31, 5'd31, 1, 32'd62, 1'b1, 1'b1, 1'b0);
    run("sub", 6'b000010, 5'd3, 5'd5, 1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    run("mul", 6'b000100, 5'd31, 5'd31, 6, 32'd961, 1'b1, 1'b1, 1'b0);
    run("mul_b", 6'b000100, 5'd13, 5'd6, 6, 32'd78, 1'b0, 1'b0, 1'b0);
    run("pop", 6'b001000, 5'd31, 5'd5, 1, 32'd7, 1'b1, 1'b0, 1'b0);
    run("illegal", 6'b000011, 5'd4, 5'd9, 1, 32'd0, 1'b0, 1'b0, 1'b1);
    run("max", 6'b100000, 5'd9, 5'd20, 1, 32'd20, 1'b0, 1'b0, 1'b0);
    run("zero_op", 6'b000000, 5'd7, 5'd7, 1, 32'd0, 1'b0, 1'b1, 1'b1);
    run("sub_zero", 6'b000010, 5'd0, 5'd0, 1, 32'd0, 1'b0, 1'b1, 1'b0);

    // Backpressure: result held for three cycles, taken in the fourth
    @(posedge clk);
    #1 out_ready = 1'b0;
    run("xor", 6'b010000, 5'd21, 5'd10, 1, 32'd31, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_out_held", out, 32'd31);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_4th", 32'(out_valid), 32'd1);
    check("bp_out_4th", out, 32'd31);
    @(negedge clk);
    check("bp_released_valid", 32'(out_valid), 32'd0);
    check("bp_released_ready", 32'(in_ready), 32'd1);

    // Reset three cycles into a multiply
    issue(6'b000100, 5'd7, 5'd3);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mid_out", out, 32'd0);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_ill", 32'(illegal_op), 32'd0);
    check("rst_mid_eq", 32'(equality), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    check("rst_no_stale_valid", 32'(seen), 32'd0);

    run("post_rst_add", 6'b000001, 5'd12, 5'd3, 1, 32'd15, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/param_alu.md
PARAM_ALU -- requirements
Module: param_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 5, meaning operand width in bits (legal 2..16).
REQ-002 SHALL have parameter OUT_W, default 32, meaning result width; OUT_W >= 2*WIDTH is checked at elaboration.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset (synchronous, active-low).
REQ-005 SHALL have port in_valid, input, 1, a request is present.
REQ-006 SHALL have port in_ready, output, 1, the block can accept a request.
REQ-007 SHALL have port num1, input, WIDTH, first unsigned operand.
REQ-008 SHALL have port num2, input, WIDTH, second unsigned operand.
REQ-009 SHALL have port operator, input, 6, one-hot opcode: bit0 Add, bit1 Sub, bit2 Mul, bit3 One_Bits_Number, bit4 XOR, bit5 Bigger_number.
REQ-010 SHALL have port out, output, OUT_W, the result.
REQ-011 SHALL have port out_valid, output, 1, out and the flags are valid.
REQ-012 SHALL have port out_ready, input, 1, the consumer accepts the result.
REQ-013 SHALL have port odd_balance, output, 1, odd parity of out.
REQ-014 SHALL have port equality, output, 1, num1 == num2 for the request.
REQ-015 SHALL have port illegal_op, output, 1, the opcode was not exactly one-hot.

Function
REQ-016 SHALL use an FSM with states IDLE, MUL and DONE; in_ready = (state == IDLE).
REQ-017 SHALL accept a request when in_valid && in_ready, capturing num1, num2, operator and equality at that edge.
REQ-018 SHALL go IDLE -> DONE on accepting a non-Mul or illegal opcode; out_valid rises on the next cycle (latency 1).
REQ-019 SHALL go IDLE -> MUL on accepting Mul, run an iterative shift-add for exactly WIDTH cycles, then go MUL -> DONE; out_valid rises WIDTH+1 cycles after accept.
REQ-020 SHALL hold out, out_valid and the flags stable in DONE until out_valid && out_ready, then go DONE -> IDLE.
REQ-021 SHALL compute Add as zero-extended num1+num2 (WIDTH+1 significant bits).
REQ-022 SHALL compute Sub as (num1 - num2) mod 2^OUT_W, so a negative result wraps to two's complement.
REQ-023 SHALL compute Mul as the full 2*WIDTH-bit unsigned product, zero-extended.
REQ-024 SHALL compute One_Bits_Number as popcount(num1) + popcount(num2).
REQ-025 SHALL compute XOR as num1 ^ num2, and Bigger_number as the unsigned maximum, both zero-extended.
REQ-026 SHALL set odd_balance to the XOR-reduction of out, valid with out_valid.
REQ-027 SHALL treat operator not exactly one-hot (including zero) as illegal: out = 0, odd_balance = 0, illegal_op = 1, latency 1; illegal_op = 0 for legal ops.
REQ-028 SHALL ignore in_valid while not IDLE; the inputs are don't-care then.

Reset
REQ-029 SHALL, on a clk edge with rst_n = 0, set state to IDLE and out, out_valid, odd_balance, equality and illegal_op to 0.
REQ-030 SHALL abort any operation in MUL or DONE when reset is applied mid-operation; the result is discarded and out_valid is never asserted for it.
REQ-031 SHALL drive in_ready = 1 in the first cycle after rst_n returns high.

Structure
REQ-032 SHALL put the one-hot opcode constants and the FSM state encoding in the shared package alu_pkg.
REQ-033 SHALL implement the multiplier as the sub-module alu_shift_add_mul (start/done, WIDTH-cycle).

Verification (WIDTH=5, OUT_W=32)
REQ-034 SHALL cover Add: num1=31, num2=31 -> out=62, odd_balance=1, equality=1, out_valid 1 cycle after accept.
REQ-035 SHALL cover Sub: num1=3, num2=5 -> out=0xFFFFFFFE, odd_balance=1, equality=0.
REQ-036 SHALL cover Mul: num1=31, num2=31 -> out=961, odd_balance=1, out_valid exactly 6 cycles after accept, in_ready=0 throughout.
REQ-037 SHALL cover backpressure: XOR of 21 and 10 with out_ready low for 3 cycles -> out=31 held stable, in_ready=0, accepted on the 4th cycle, then IDLE.
REQ-038 SHALL cover illegal opcode: operator=6'b000011 -> out=0, illegal_op=1, odd_balance=0; the next legal request has illegal_op=0.
REQ-039 SHALL cover reset mid-operation: rst_n low 3 cycles into a Mul -> all outputs 0, no out_valid, in_ready=1 one cycle after release.
